// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Core-side initiator for the data-memory port. Takes one load or store at a
// time from the execute stage, drives a single memory access and returns a
// one-cycle completion pulse with extended load data or an error flag.
//
// Parameters
//   TIMEOUT         cycles the unit waits in READ for mem_valid before erroring (>= 1)
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           asynchronous, active-low reset
//   req_valid       core presents a request
//   req_ready       unit idle; request accepted on req_valid && req_ready
//   req_store       1 = store, 0 = load
//   req_funct3      RV32I width/sign code
//   req_addr        byte address
//   req_wdata       store data, right-aligned
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load data (0 for stores and errors)
//   resp_error      misaligned access, illegal funct3 or read timeout
//   mem_addr        word-aligned byte address
//   mem_mask        byte-lane enables, bit i covers bits [8i+7:8i]
//   mem_enable      memory access active
//   mem_cmd         0 = read, 1 = write
//   mem_write_data  lane-aligned store data, unused lanes driven 0
//   mem_load_data   full word returned by memory
//   mem_valid       mem_load_data valid (may be combinational from mem_addr)

module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  // Core request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  // Core response
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  // Memory port
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_mask,
  output logic        mem_enable,
  output logic        mem_cmd,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_load_data,
  input  logic        mem_valid
);

  // Command encoding shared with the memory (same values as defines.vh).
  localparam logic MemCmdRead  = 1'b0;
  localparam logic MemCmdWrite = 1'b1;

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Last READ cycle allowed without mem_valid.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Latched request
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Read timeout counter
  logic [CntW-1:0] cnt_q, cnt_d;

  // Registered response
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic        accept;
  logic        funct3_bad;
  logic        misaligned;
  logic        req_bad;

  logic [3:0]  lane_mask;
  logic [31:0] lane_bits;
  logic [31:0] wdata_lane;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;

  assign accept = req_valid && (state_q == StIdle);

  //--------------------------------------------------------------------------
  // Request legality, decided at accept time from the live request
  //--------------------------------------------------------------------------
  always_comb begin
    funct3_bad = 1'b0;
    misaligned = 1'b0;

    if (req_store) begin
      // Stores: only SB/SH/SW.
      funct3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      // Loads: 011, 110 and 111 are unused.
      funct3_bad = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    end

    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    req_bad = funct3_bad || misaligned;
  end

  //--------------------------------------------------------------------------
  // Lane decode, from latched request only
  //--------------------------------------------------------------------------
  always_comb begin
    lane_mask = 4'b0000;
    case (funct3_q[1:0])
      2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
      2'b01:   lane_mask = 4'b0011 << addr_q[1:0];
      default: lane_mask = 4'b1111;
    endcase
  end

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < 4; i++) begin
      lane_bits[8*i +: 8] = {8{lane_mask[i]}};
    end
  end

  // Lanes outside the mask are forced to 0 rather than left as shifted junk.
  assign wdata_lane = (wdata_q << {addr_q[1:0], 3'b000}) & lane_bits;

  //--------------------------------------------------------------------------
  // Load extraction and extension
  //--------------------------------------------------------------------------
  assign load_shifted = mem_load_data >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = load_shifted;
    case (funct3_q)
      3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b100:  load_ext = {24'h000000, load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b101:  load_ext = {16'h0000, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d = '0;
          if (req_bad) begin
            // Rejected requests never touch memory.
            state_d = StResp;
            rdata_d = '0;
            error_d = 1'b1;
          end else if (req_store) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end

      StWrite: begin
        // Writes are fire-and-forget: one enable cycle, no acknowledge.
        state_d = StResp;
        rdata_d = '0;
        error_d = 1'b0;
      end

      StRead: begin
        if (mem_valid) begin
          state_d = StResp;
          rdata_d = load_ext;
          error_d = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d = StResp;
          rdata_d = '0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (accept) begin
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  //--------------------------------------------------------------------------
  // Outputs, decoded from flops only
  //--------------------------------------------------------------------------
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  assign mem_enable     = (state_q == StRead) || (state_q == StWrite);
  assign mem_cmd        = (state_q == StWrite) ? MemCmdWrite : MemCmdRead;
  assign mem_addr       = mem_enable ? {addr_q[31:2], 2'b00} : '0;
  assign mem_mask       = mem_enable ? lane_mask : '0;
  assign mem_write_data = (state_q == StWrite) ? wdata_lane : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit. The driver pushes expected responses
// and expected write transactions, computed from a byte-addressed reference
// memory, into queues; an independent monitor pops and compares them when the
// DUT presents a response or a write. A memory responder returns load data
// after a per-request latency and applies the DUT's writes to its own store.

module tb_mem_access_unit;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic        mem_enable;
  logic        mem_cmd;
  logic [31:0] mem_write_data;
  logic [31:0] mem_load_data = '0;
  logic        mem_valid = 1'b0;

  mem_access_unit #(.TIMEOUT(T)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_addr       (mem_addr),
    .mem_mask       (mem_mask),
    .mem_enable     (mem_enable),
    .mem_cmd        (mem_cmd),
    .mem_write_data (mem_write_data),
    .mem_load_data  (mem_load_data),
    .mem_valid      (mem_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          en;
    int          at;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];

  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] phys    [logic [31:0]];
  int cur_lat = 0;
  int rd_cnt = 0;
  int en_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Initial memory image: word 0x100 holds 0x8899AABB, others a fixed pattern.
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h8899AABB;
    if (a[31:2] == 30'h40) return w[8*a[1:0] +: 8];
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] wa);
    logic [31:0] v;
    if (phys.exists(wa)) return phys[wa];
    for (int i = 0; i < 4; i++) v[8*i +: 8] = init_byte(wa + 32'(i));
    return v;
  endfunction

  function automatic int access_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_legal(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = access_size(f3);
    if (st && f3 > 3'd2) return 0;
    if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    return (a % n) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = '0;
    n = access_size(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + 32'(i));
    if (!f3[2] && n == 1 && v[7])  v[31:8]  = '1;
    if (!f3[2] && n == 2 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  // Memory responder: mem_valid on the lat-th READ cycle, random noise elsewhere.
  always @(negedge clk) begin
    if (mem_enable && mem_cmd == 1'b0) begin
      rd_cnt++;
      mem_valid = (rd_cnt == cur_lat);
      mem_load_data = mem_valid ? phys_rd(mem_addr) : $urandom;
    end else begin
      rd_cnt = 0;
      mem_valid = 1'($urandom_range(0, 1));
      mem_load_data = $urandom;
      if (mem_enable && mem_cmd == 1'b1) begin
        logic [31:0] w;
        w = phys_rd(mem_addr);
        for (int i = 0; i < 4; i++)
          if (mem_mask[i]) w[8*i +: 8] = mem_write_data[8*i +: 8];
        phys[mem_addr] = w;
      end
    end
  end

  // Monitor
  resp_t mr;
  wr_t   mw;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_enable) en_cnt++;
      if (!mem_enable) begin
        chk("idle_mem_addr", mem_addr, 32'h0);
        chk("idle_mem_mask_cmd", {27'h0, mem_mask, mem_cmd}, 32'h0);
        chk("idle_mem_wdata", mem_write_data, 32'h0);
      end else if (mem_cmd == 1'b1) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'h1, 32'h0);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", mem_addr, mw.addr);
          chk("wr_mask", {28'h0, mem_mask}, {28'h0, mw.mask});
          chk("wr_data", mem_write_data, mw.data);
        end
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 32'h1, 32'h0);
        end else begin
          mr = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, mr.rdata);
          chk("resp_error", {31'h0, resp_error}, {31'h0, mr.err});
          chk("enable_cycles", 32'(en_cnt), 32'(mr.en));
          chk("resp_cycle", 32'(cyc), 32'(mr.at));
        end
        en_cnt = 0;
      end
    end
  end

  // Present a request, wait for acceptance, record the expected outcome.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat);
    resp_t r;
    wr_t   w;
    int    n;
    bit    got;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", 32'h1, 32'h0);
      req_valid = 1'b0;
      return;
    end
    cur_lat = lat;
    n = access_size(f3);
    if (!is_legal(st, f3, a)) begin
      r = '{rdata: 32'h0, err: 1'b1, en: 0, at: cyc + 1};
    end else if (st) begin
      w.addr = {a[31:2], 2'b00};
      w.mask = '0;
      w.data = '0;
      for (int i = 0; i < n; i++) begin
        logic [31:0] ba;
        ba = a + 32'(i);
        ref_mem[ba] = wd[8*i +: 8];
        w.mask[ba[1:0]] = 1'b1;
        w.data[8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
      wr_q.push_back(w);
      r = '{rdata: 32'h0, err: 1'b0, en: 1, at: cyc + 2};
    end else if (lat <= int'(T)) begin
      r = '{rdata: ref_load(f3, a), err: 1'b0, en: lat, at: cyc + lat + 1};
    end else begin
      r = '{rdata: 32'h0, err: 1'b1, en: int'(T), at: cyc + int'(T) + 1};
    end
    resp_q.push_back(r);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  load_codes [5];
    load_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;

    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
    chk("rst_mem_enable", {31'h0, mem_enable}, 32'h0);
    chk("rst_mem_cmd", {31'h0, mem_cmd}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_mask", {28'h0, mem_mask}, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Extraction on word 0x100 = 0x8899AABB, same-cycle mem_valid.
    issue(1'b0, 3'b000, 32'h101, 32'h0, 1);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 1);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 1);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1);
    // Byte store then readback.
    issue(1'b1, 3'b000, 32'h102, 32'h12345677, 1);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 1);
    // Rejected requests.
    issue(1'b0, 3'b010, 32'h102, 32'h0, 1);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 1);
    issue(1'b1, 3'b011, 32'h100, 32'h0, 1);
    issue(1'b1, 3'b001, 32'h101, 32'h0, 1);
    // Timeout, then late-but-in-time data.
    issue(1'b0, 3'b010, 32'h200, 32'h0, 99);
    issue(1'b0, 3'b010, 32'h200, 32'h0, 3);
    issue(1'b0, 3'b010, 32'h200, 32'h0, int'(T));

    // Reset during READ cycle 2 discards the request.
    issue(1'b0, 3'b010, 32'h104, 32'h0, 99);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_mem_enable", {31'h0, mem_enable}, 32'h0);
    chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    resp_q.delete();
    en_cnt = 0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 3'b010, 32'h104, 32'h0, 2);

    // Back-to-back with req_valid held: SH then LHU.
    issue(1'b1, 3'b001, 32'h106, 32'h0000BEEF, 1);
    issue(1'b0, 3'b101, 32'h106, 32'h0, 2);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      st = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = load_codes[$urandom_range(0, 4)];
      a = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        else if (f3[1:0] != 2'b00) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      issue(st, f3, a, $urandom, $urandom_range(1, int'(T) + 2));
    end

    for (int i = 0; i < 40 && (resp_q.size() != 0 || wr_q.size() != 0); i++) @(posedge clk);
    chk("drain_resp_q", 32'(resp_q.size()), 32'h0);
    chk("drain_wr_q", 32'(wr_q.size()), 32'h0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
